mult_operand_sequencer: RTL and testbench

//   Upstream feeder for the 8x8 sequential multiplier. Accepts operand pairs over
//   a valid/ready handshake and buffers them in a small FIFO. Issues each pair to
//   the multiplier as a one-cycle start pulse, then holds the operands stable for
//   the fixed multiply time. Captures the 16-bit product and presents it

---
 rtl/mult_operand_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_mult_operand_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_operand_sequencer.sv
// Operand feeder for an external sequential multiplier: buffers operand pairs in a
// small FIFO, issues one start pulse per pair, waits the multiply time, holds the product.
module mult_operand_sequencer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MUL_CYCLES = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_data,
    output logic                 busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] CNT_LOAD = TW'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [PW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_head;

    // FSM and output registers
    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_cnt;
    logic [TW-1:0] w_cnt_nxt;
    logic          r_mul_start;
    logic          w_mul_start_nxt;
    logic [WIDTH-1:0] r_mul_a;
    logic [WIDTH-1:0] w_mul_a_nxt;
    logic [WIDTH-1:0] r_mul_b;
    logic [WIDTH-1:0] w_mul_b_nxt;
    logic          r_res_valid;
    logic          w_res_valid_nxt;
    logic [PW-1:0] r_res_data;
    logic [PW-1:0] w_res_data_nxt;
    logic          r_busy;
    logic          w_busy_nxt;

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    // No bypass: a full FIFO refuses even in a popping cycle
    assign in_ready = !w_full && !rst;
    assign w_push   = in_valid && in_ready;
    assign w_head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Next-state and output decode; a pending result blocks the next issue
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_mul_start_nxt = 1'b0;
        w_mul_a_nxt     = r_mul_a;
        w_mul_b_nxt     = r_mul_b;
        w_res_valid_nxt = r_res_valid;
        w_res_data_nxt  = r_res_data;
        w_pop           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop           = 1'b1;
                    w_mul_a_nxt     = w_head[PW-1:WIDTH];
                    w_mul_b_nxt     = w_head[WIDTH-1:0];
                    w_mul_start_nxt = 1'b1;
                    w_state_nxt     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_cnt_nxt   = CNT_LOAD;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_res_data_nxt  = mul_out;
                    w_res_valid_nxt = 1'b1;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - TW'(1);
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    w_res_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mul_start <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mul_start <= w_mul_start_nxt;
            r_mul_a     <= w_mul_a_nxt;
            r_mul_b     <= w_mul_b_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_data  <= w_res_data_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed bench for mult_operand_sequencer with a behavioural multiplier of
// MUL_CYCLES latency attached to the mul_* ports.
module tb_mult_operand_sequencer;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned MUL_CYCLES = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        mul_start;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_out;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [7:0]  pa [6];
    logic [7:0]  pb [6];
    logic [15:0] exp_q [5];

    mult_operand_sequencer #(
        .WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .MUL_CYCLES(MUL_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier model: samples operands on the start edge, product valid MUL_CYCLES-1 edges later
    logic [7:0] m_a, m_b;
    int         m_rem;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_out <= 16'h0;
            m_rem   <= 0;
            m_a     <= 8'h0;
            m_b     <= 8'h0;
        end else if (mul_start) begin
            m_a     <= mul_a;
            m_b     <= mul_b;
            m_rem   <= MUL_CYCLES - 1;
            mul_out <= (MUL_CYCLES == 1) ? {8'h0, mul_a} * {8'h0, mul_b} : 16'hBEEF;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) mul_out <= {8'h0, m_a} * {8'h0, m_b};
        end
    end

    task automatic push_one(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Consecutive pushes from pa/pb starting from an idle, empty sequencer
    task automatic push_seq(input int n);
        logic exp_rdy;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = pa[i];
            in_b = pb[i];
            #1;
            exp_rdy = (i < 5) ? 1'b1 : 1'b0;
            total++;
            if (in_ready !== exp_rdy) begin
                bad++;
                $display("FAIL push_ready beat %0d: got %b expected %b", i, in_ready, exp_rdy);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (res_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Caller holds res_ready=1 and calls away from a clock edge
    task automatic collect(input int n);
        bit ok;
        for (int j = 0; j < n; j++) begin
            wait_result(ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL result %0d: timeout waiting for res_valid, expected %0d", j, exp_q[j]);
            end else if (res_data !== exp_q[j]) begin
                bad++;
                $display("FAIL result %0d: got %0d expected %0d", j, res_data, exp_q[j]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_quiet(input string name);
        bit seen;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (res_valid !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL %s extra_result: res_valid got 1 expected 0", name);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_busy: got %b expected 0", name, busy);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, mul_start, mul_a, mul_b, res_valid, res_data, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b start=%b a=%0d b=%0d rv=%b rd=%0d busy=%b expected all 0",
                     in_ready, mul_start, mul_a, mul_b, res_valid, res_data, busy);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: ready=%b busy=%b rv=%b expected 1 0 0", in_ready, busy, res_valid);
        end
    endtask

    task automatic test_single();
        logic exp_start, exp_rv;
        res_ready = 1'b1;
        push_one(8'd2, 8'd2);
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_start = (k == 1) ? 1'b1 : 1'b0;
            exp_rv    = (k == 11) ? 1'b1 : 1'b0;
            total++;
            if (mul_start !== exp_start) begin
                bad++;
                $display("FAIL single_start cycle %0d: got %b expected %b", k, mul_start, exp_start);
            end
            total++;
            if (res_valid !== exp_rv) begin
                bad++;
                $display("FAIL single_valid cycle %0d: got %b expected %b", k, res_valid, exp_rv);
            end
            if (k == 1) begin
                total++;
                if (mul_a !== 8'd2 || mul_b !== 8'd2) begin
                    bad++;
                    $display("FAIL single_operands: got %0d,%0d expected 2,2", mul_a, mul_b);
                end
            end
        end
        total++;
        if (res_data !== 16'd4) begin
            bad++;
            $display("FAIL single_data: got %0d expected 4", res_data);
        end
        check_quiet("single");
    endtask

    task automatic test_burst();
        pa = '{8'd5, 8'd1, 8'd11, 8'd51, 8'd247, 8'd2};
        pb = '{8'd3, 8'd7, 8'd6,  8'd11, 8'd179, 8'd3};
        exp_q = '{16'd15, 16'd7, 16'd66, 16'd561, 16'd44213};
        res_ready = 1'b1;
        push_seq(6);
        collect(5);
        check_quiet("burst");
    endtask

    task automatic test_back_pressure();
        bit ok;
        pa[0:4] = '{8'd9, 8'd10, 8'd12, 8'd4, 8'd6};
        pb[0:4] = '{8'd9, 8'd10, 8'd3,  8'd5, 8'd7};
        exp_q = '{16'd81, 16'd100, 16'd36, 16'd20, 16'd42};
        res_ready = 1'b0;
        push_seq(5);
        wait_result(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL stall_first: timeout waiting for res_valid, expected 81");
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            total++;
            if (res_valid !== 1'b1 || res_data !== 16'd81 || mul_start !== 1'b0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall cycle %0d: rv=%b rd=%0d start=%b ready=%b expected 1 81 0 0",
                         k, res_valid, res_data, mul_start, in_ready);
            end
        end
        res_ready = 1'b1;
        collect(5);
        check_quiet("stall");
    endtask

    task automatic test_boundaries();
        pa = '{8'd255, 8'd0,   8'd16, 8'd200, 8'd13, 8'd99};
        pb = '{8'd255, 8'd200, 8'd16, 8'd2,   8'd13, 8'd99};
        exp_q = '{16'd65025, 16'd0, 16'd256, 16'd400, 16'd169};
        res_ready = 1'b1;
        push_seq(6);
        collect(5);
        check_quiet("bounds");
    endtask

    task automatic test_reset_midop();
        res_ready = 1'b1;
        push_one(8'd3, 8'd4);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({in_ready, mul_start, mul_a, mul_b, res_valid, res_data, busy} !== '0) begin
            bad++;
            $display("FAIL midop_reset: ready=%b start=%b a=%0d b=%0d rv=%b rd=%0d busy=%b expected all 0",
                     in_ready, mul_start, mul_a, mul_b, res_valid, res_data, busy);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midop_release: ready=%b busy=%b expected 1 0", in_ready, busy);
        end
        exp_q[0] = 16'd56;
        push_one(8'd7, 8'd8);
        collect(1);
        check_quiet("midop");
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_back_pressure();
        test_boundaries();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
